// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces presses, and
// emits a 1-cycle key code (or '#' clear strobe) per accepted press.
// Ports:
//   clk, n_reset   clock and synchronous active-high reset
//   row_in[3:0]    keypad rows, active-low (pulled up)
//   col_out[3:0]   column drive, active-low one-hot
//   sample[3:0]    key code for one cycle per press, else 4'hF
//   sample_valid   high with sample when sample != 4'hF
//   clear_pulse    one-cycle strobe for an accepted '#'
//   key_held       high from acceptance until release is debounced
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] sample,
   output logic       sample_valid,
   output logic       clear_pulse,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);
   localparam logic [3:0]    HASH     = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED
   } state_t;

   state_t        state;
   logic [3:0]    row_s1;
   logic [3:0]    row_s2;
   logic [DW-1:0] div_cnt;
   logic [1:0]    col_idx;
   logic [1:0]    acc_n;
   logic [3:0]    acc_code;
   logic [3:0]    cand;
   logic [CW-1:0] cnt;
   logic [CW-1:0] rcnt;

   logic       last_dwell;
   logic       scan_done;
   logic [3:0] hit;
   logic [2:0] hit_n;
   logic [1:0] hit_sat;
   logic [1:0] hit_row;
   logic [2:0] tot;
   logic [1:0] tot_n;
   logic [3:0] sum_code;

   function automatic logic [3:0] key_code(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] k;
      case ({r, c})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hA;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hB;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hC;
         4'b11_00: k = 4'hE;
         4'b11_01: k = 4'h0;
         4'b11_10: k = HASH;
         4'b11_11: k = 4'hD;
      endcase
      return k;
   endfunction

   assign last_dwell = (div_cnt == DIV_LAST);
   assign scan_done  = last_dwell && (col_idx == 2'd3);
   assign hit        = ~row_s2;

   // Per-column key count folded into a saturating
   // scan tally: 0 = NONE, 1 = SINGLE, 2 = MULTI.
   always_comb begin
      hit_n = 3'(hit[0]) + 3'(hit[1])
            + 3'(hit[2]) + 3'(hit[3]);
      hit_sat = (hit_n > 3'd1) ? 2'd2 : hit_n[1:0];
      tot = {1'b0, acc_n} + {1'b0, hit_sat};
      tot_n = (tot > 3'd1) ? 2'd2 : tot[1:0];
      hit_row = 2'd0;
      case (1'b1)
         hit[0]:  hit_row = 2'd0;
         hit[1]:  hit_row = 2'd1;
         hit[2]:  hit_row = 2'd2;
         hit[3]:  hit_row = 2'd3;
         default: hit_row = 2'd0;
      endcase
      sum_code = acc_code;
      if (acc_n == 2'd0 && hit_n == 3'd1)
         sum_code = key_code(hit_row, col_idx);
   end

   always_ff @(posedge clk) begin
      if (n_reset) begin
         state        <= IDLE;
         row_s1       <= 4'hF;
         row_s2       <= 4'hF;
         div_cnt      <= '0;
         col_idx      <= 2'd0;
         col_out      <= 4'b1110;
         acc_n        <= 2'd0;
         acc_code     <= 4'hF;
         cand         <= 4'hF;
         cnt          <= '0;
         rcnt         <= '0;
         sample       <= 4'hF;
         sample_valid <= 1'b0;
         clear_pulse  <= 1'b0;
         key_held     <= 1'b0;
      end else begin
         sample       <= 4'hF;
         sample_valid <= 1'b0;
         clear_pulse  <= 1'b0;
         row_s1       <= row_in;
         row_s2       <= row_s1;

         if (last_dwell) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            col_out <= {col_out[2:0], col_out[3]};
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end

         if (last_dwell && !scan_done) begin
            acc_n    <= tot_n;
            acc_code <= sum_code;
         end

         if (scan_done) begin
            acc_n    <= 2'd0;
            acc_code <= 4'hF;
            case (state)
               IDLE: begin
                  if (tot_n == 2'd1) begin
                     cand  <= sum_code;
                     cnt   <= CW'(1);
                     state <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (tot_n == 2'd1 && sum_code == cand) begin
                     if (cnt >= CNT_LAST) begin
                        cnt      <= CNT_MAX;
                        rcnt     <= '0;
                        state    <= PRESSED;
                        key_held <= 1'b1;
                        // '#' shares the idle code, so it
                        // gets its own strobe instead.
                        if (cand == HASH) begin
                           clear_pulse <= 1'b1;
                        end else begin
                           sample       <= cand;
                           sample_valid <= 1'b1;
                        end
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
               PRESSED: begin
                  if (tot_n == 2'd0) begin
                     if (rcnt >= CNT_LAST) begin
                        rcnt     <= '0;
                        cnt      <= '0;
                        state    <= IDLE;
                        key_held <= 1'b0;
                     end else begin
                        rcnt <= rcnt + CW'(1);
                     end
                  end else begin
                     rcnt <= '0;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled keypad into keypad_scanner and
// compares every cycle against a scan-level reference model.
module tb_keypad_scanner;

   localparam int SD  = 4;
   localparam int DEB = 3;

   logic       clk = 1'b0;
   logic       n_reset;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] sample;
   logic       sample_valid;
   logic       clear_pulse;
   logic       key_held;

   logic [15:0] keys;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [3:0] kmap [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   int         m_state;
   logic [3:0] m_cand;
   int         m_cnt;
   int         m_rcnt;
   int         m_n;
   logic [3:0] m_code;
   int         pend_cyc;
   bit         pend_emit;
   bit         pend_clr;
   bit         pend_held;
   logic [3:0] pend_sample;
   bit         exp_held;

   logic [4:0] obs [$];
   int         last_emit_cyc;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV(SD),
      .DEBOUNCE_CNT(DEB)
   ) dut (
      .clk(clk),
      .n_reset(n_reset),
      .row_in(row_in),
      .col_out(col_out),
      .sample(sample),
      .sample_valid(sample_valid),
      .clear_pulse(clear_pulse),
      .key_held(key_held)
   );

   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_out[c])
               row_in[r] = 1'b0;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  tag, cyc, got, exp);
      end
   endtask

   function automatic logic [15:0] kb(input int r, input int c);
      return 16'h1 << (r*4 + c);
   endfunction

   task automatic model_reset();
      m_state  = 0;
      m_cnt    = 0;
      m_rcnt   = 0;
      m_n      = 0;
      m_code   = 4'hF;
      m_cand   = 4'hF;
      pend_cyc = -1;
      exp_held = 1'b0;
   endtask

   // Rows reach the scanner two cycles late, so column c of
   // scan n sees the keypad as it was in cycle 16n+4c+1.
   task automatic model_cycle();
      int ph;
      int c;
      ph = cyc % (4*SD);
      if (cyc % SD == SD - 3) begin
         c = ph / SD;
         for (int r = 0; r < 4; r++)
            if (keys[r*4+c]) begin
               m_n++;
               if (m_n == 1) m_code = kmap[r*4+c];
            end
      end
      if (ph == 4*SD - 3) begin
         if (m_state == 0) begin
            if (m_n == 1) begin
               m_cand  = m_code;
               m_cnt   = 1;
               m_state = 1;
            end
         end else if (m_state == 1) begin
            if (m_n == 1 && m_code == m_cand) begin
               m_cnt++;
               if (m_cnt == DEB) begin
                  m_state     = 2;
                  m_rcnt      = 0;
                  pend_cyc    = cyc + 3;
                  pend_emit   = 1'b1;
                  pend_clr    = (m_cand == 4'hF);
                  pend_sample = m_cand;
                  pend_held   = 1'b1;
               end
            end else begin
               m_state = 0;
               m_cnt   = 0;
            end
         end else begin
            if (m_n == 0) begin
               m_rcnt++;
               if (m_rcnt == DEB) begin
                  m_state   = 0;
                  m_cnt     = 0;
                  m_rcnt    = 0;
                  pend_cyc  = cyc + 3;
                  pend_emit = 1'b0;
                  pend_held = 1'b0;
               end
            end else begin
               m_rcnt = 0;
            end
         end
         m_n = 0;
      end
   endtask

   task automatic check_cycle();
      logic [3:0] es;
      logic [3:0] ec;
      bit ev;
      bit ecl;
      es  = 4'hF;
      ev  = 1'b0;
      ecl = 1'b0;
      if (cyc == pend_cyc) begin
         exp_held = pend_held;
         if (pend_emit) begin
            if (pend_clr) ecl = 1'b1;
            else begin
               es = pend_sample;
               ev = 1'b1;
            end
         end
         pend_cyc = -1;
      end
      ec = ~(4'b0001 << ((cyc / SD) % 4));
      chk("col_out", col_out, ec);
      chk("sample", sample, es);
      chk("sample_valid", sample_valid, ev);
      chk("clear_pulse", clear_pulse, ecl);
      chk("key_held", key_held, exp_held);
      if (sample_valid) obs.push_back({1'b0, sample});
      if (clear_pulse)  obs.push_back(5'h1F);
      if (sample_valid || clear_pulse) last_emit_cyc = cyc;
   endtask

   task automatic step(input logic [15:0] k);
      @(posedge clk);
      #1;
      cyc++;
      check_cycle();
      keys = k;
      model_cycle();
   endtask

   task automatic hold(input logic [15:0] k, input int n);
      repeat (n) step(k);
   endtask

   task automatic align();
      while ((cyc + 1) % (4*SD) != 0) step(keys);
   endtask

   task automatic do_reset(input logic [15:0] k);
      keys    = k;
      n_reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_col", col_out, 4'b1110);
         chk("rst_sample", sample, 4'hF);
         chk("rst_valid", sample_valid, 1'b0);
         chk("rst_clear", clear_pulse, 1'b0);
         chk("rst_held", key_held, 1'b0);
      end
      n_reset = 1'b0;
      cyc = 0;
      model_reset();
      check_cycle();
      model_cycle();
   endtask

   logic [4:0] seq_exp [6] = '{
      5'h05, 5'h03, 5'h04, 5'h09, 5'h06, 5'h01
   };
   int seq_r [6] = '{1, 0, 1, 2, 1, 0};
   int seq_c [6] = '{1, 2, 0, 2, 2, 0};

   initial begin
      int base;
      int t0;
      logic [15:0] rk;

      n_reset = 1'b1;
      keys = '0;
      last_emit_cyc = -1;
      model_reset();
      do_reset('0);
      hold('0, 20);

      align();
      base = obs.size();
      t0 = cyc + 1;
      hold(kb(1, 1), 120);
      hold('0, 80);
      chk("k5_count", obs.size() - base, 1);
      if (obs.size() > base) chk("k5_val", obs[base], 5'h05);
      chk("k5_latency", last_emit_cyc - t0, 48);

      align();
      base = obs.size();
      hold(kb(0, 2), 16);
      hold('0, 64);
      chk("bounce_count", obs.size() - base, 0);

      base = obs.size();
      for (int i = 0; i < 6; i++) begin
         hold(kb(seq_r[i], seq_c[i]), 80);
         hold('0, 80);
      end
      chk("seq_count", obs.size() - base, 6);
      for (int i = 0; i < 6; i++)
         if (obs.size() > base + i)
            chk("seq_val", obs[base+i], seq_exp[i]);

      base = obs.size();
      hold(kb(3, 2), 80);
      hold('0, 80);
      chk("hash_count", obs.size() - base, 1);
      if (obs.size() > base) chk("hash_val", obs[base], 5'h1F);

      base = obs.size();
      hold(kb(3, 0), 80);
      hold('0, 80);
      chk("star_count", obs.size() - base, 1);
      if (obs.size() > base) chk("star_val", obs[base], 5'h0E);

      base = obs.size();
      hold(kb(0, 0) | kb(0, 1), 80);
      hold('0, 80);
      chk("multi_count", obs.size() - base, 0);

      align();
      base = obs.size();
      hold(kb(2, 0), 20);
      do_reset(kb(2, 0));
      hold(kb(2, 0), 80);
      hold('0, 80);
      chk("rst7_count", obs.size() - base, 1);
      if (obs.size() > base) chk("rst7_val", obs[base], 5'h07);
      chk("rst7_latency", last_emit_cyc, 48);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: rk = '0;
            3: rk = kb($urandom_range(0, 3), $urandom_range(0, 3))
                  | kb($urandom_range(0, 3), $urandom_range(0, 3));
            default: rk = kb($urandom_range(0, 3),
                             $urandom_range(0, 3));
         endcase
         hold(rk, $urandom_range(4, 70));
      end
      hold('0, 80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
